mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped peripheral responder on the far side of the CPU's MMIO port.
- Decodes CPU stores presented on memMappedAddr/memMappedDataOut and drives an LED register.
- Queues graphics commands into an 8-deep FIFO and hands them to the display engine over a valid/ready handshake.
- Returns a packed joystick/status word on joystick_data, which the CPU samples for every MMIO load.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button level change is accepted (minimum 2).
- FIFO_DEPTH, 8, command FIFO entries; must be a power of two.
- NUM_BTN, 8, number of button inputs (maximum 8).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- memMappedAddr  in  32  CPU MMIO store address; 0 when no store
- memMappedDataOut  in  32  CPU MMIO store data
- joystick_data  out  32  status word read by the CPU
- btn_raw  in  NUM_BTN  asynchronous button pins
- led  out  8  LED register
- cmd_valid  out  1  FIFO head valid
- cmd_data  out  32  FIFO head data
- cmd_ready  in  1  display engine accepts head

Behaviour:
- Reset: applied at the clock edge while rst=1. All flops clear: led=0, cmd_valid=0, cmd_data=0, FIFO empty, sync/debounce state 0, sticky bits 0, joystick_data=0. Reset mid-transfer discards all FIFO contents.
- Store strobe: wr = |memMappedAddr[31:15]. Register decode uses the full 32-bit address:
  - 0x0000_8000 CMD_PUSH: push data into the FIFO.
  - 0x0000_8004 LED: led <= data[7:0].
  - 0x0000_8008 EDGE_CLR: clear edge bits where data[7:0]=1; data[8]=1 clears overflow.
  - Any other address with wr=1 is ignored.
  - Stores take effect at the edge ending the cycle in which they are presented. Every cycle with wr=1 is a distinct store; there is no hold or dedupe.
- Button sync: 2-flop synchronizer per bit.
- Debounce, per button, with counter width clog2(DEBOUNCE_CYCLES):
  - If synced == stable, count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1, stable <= synced and count <= 0.
  - Else count++.
  - Pin-change to stable-change latency = 2 + DEBOUNCE_CYCLES cycles.
- Edge capture: edge[i] sets on a 0->1 transition of stable[i]. If set and clear hit the same bit in the same cycle, set wins.
- FIFO:
  - pop = cmd_valid & cmd_ready.
  - push accepted = CMD_PUSH & (!full | pop).
  - CMD_PUSH while full with no pop: data dropped, overflow sticky <= 1. If overflow set and EDGE_CLR clear coincide, set wins.
  - Simultaneous push and pop when empty: no pop occurs; the push lands and cmd_valid=1 next cycle.
  - cmd_data is the registered head, shown first-word-fall-through. It is valid one cycle after the push into an empty FIFO and must not change while cmd_valid & !cmd_ready.
  - Count ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- joystick_data is registered every cycle, so it reflects state one cycle old:
  - [7:0] stable buttons
  - [15:8] edge bits
  - [19:16] FIFO count (low 4 bits)
  - [20] full
  - [21] overflow
  - [31:22] 0
  - Unused button bits read 0.

Decomposition:
- Package mmio_pkg: address constants MMIO_CMD_PUSH, MMIO_LED, MMIO_EDGE_CLR; status bit-position localparams; an MMIO_REGION_MSB/LSB constant pair (31:15).
- One sub-module, mmio_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, instantiated once.
- Debounce stays inline as a generate loop.

Test Plan:
- Reset: assert rst for 2 cycles mid-operation with 3 commands queued -> next cycle cmd_valid=0, led=0, joystick_data=0x0000_0000.
- LED write: addr=0x8004, data=0xFFFF_FFA5 for one cycle -> led=0xA5 next cycle. Then addr=0x0 and addr=0x8010 with data=0x11 -> led stays 0xA5.
- Debounce (DEBOUNCE_CYCLES=4):
  - btn_raw[2] 0->1 glitch for 3 cycles -> joystick_data[2] stays 0.
  - Hold 1 for 10 cycles -> bit 2 sets 6 cycles after the pin change and edge bit 10 sets.
  - Store to 0x8008 data=0x004 in the same cycle edge[2] rises -> bit 10 remains 1. A later clear makes it 0.
- FIFO fill with cmd_ready=0: push 0x100..0x107 -> full=1, count field=8 (bits [19:16]=0x8). Push 0x108 -> dropped, overflow=1. Drain -> 0x100..0x107 emitted in order, 0x108 never appears.
- Full with push+pop in the same cycle: count stays 8, overflow stays 0, and the new word appears last.
- Empty FIFO, push with cmd_ready=1 held: cmd_valid=1 one cycle later, then accepted; count returns to 0. cmd_data held stable throughout a 5-cycle backpressure window.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO constants: register addresses, store-region bounds, status word
// layout and the store decoder used by the responder.
package mmio_pkg;

  // A store is in flight whenever any address bit in this range is set.
  localparam int MMIO_REGION_MSB = 31;
  localparam int MMIO_REGION_LSB = 15;

  localparam logic [31:0] MMIO_CMD_PUSH = 32'h0000_8000;
  localparam logic [31:0] MMIO_LED      = 32'h0000_8004;
  localparam logic [31:0] MMIO_EDGE_CLR = 32'h0000_8008;

  // Status word layout seen on joystick_data.
  localparam int ST_BTN_LSB  = 0;
  localparam int ST_EDGE_LSB = 8;
  localparam int ST_CNT_LSB  = 16;
  localparam int ST_FULL_BIT = 20;
  localparam int ST_OVF_BIT  = 21;

  typedef struct packed {
    logic push;
    logic led;
    logic edge_clr;
  } mmio_dec_t;

  // Full 32-bit match; any other address with the strobe up is ignored.
  function automatic mmio_dec_t mmio_decode(input logic wr, input logic [31:0] addr);
    mmio_dec_t d;
    d.push     = wr && (addr == MMIO_CMD_PUSH);
    d.led      = wr && (addr == MMIO_LED);
    d.edge_clr = wr && (addr == MMIO_EDGE_CLR);
    return d;
  endfunction

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Synchronous command FIFO with a registered first-word-fall-through head.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module mmio_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok = push & (~full | pop_ok);
  assign rd_nxt  = rd_ptr + AW'(pop_ok);

  // Storage, pointers, count and the head register. The head is reloaded
  // from the slot the read pointer will point at; when that slot is being
  // written this cycle the incoming word bypasses the array. With no pop the
  // head slot is never overwritten, so head holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      count  <= count + CW'(push_ok) - CW'(pop_ok);
      head   <= (push_ok && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: decodes CPU stores into LED / command-push / edge-clear
// actions, debounces the buttons and returns a registered status word.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,  // >= 2
  parameter int FIFO_DEPTH      = 8,   // power of two
  parameter int NUM_BTN         = 8    // <= 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        memMappedAddr,
  input  logic [31:0]        memMappedDataOut,
  output logic [31:0]        joystick_data,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [7:0]         led,
  output logic               cmd_valid,
  output logic [31:0]        cmd_data,
  input  logic               cmd_ready
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               wr;
  mmio_dec_t          dec;
  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] stable, stable_nxt, rise, clr_mask;
  logic [NUM_BTN-1:0] edge_bits;
  logic               ovf, ovf_set, ovf_clr;
  logic               full, empty, pop;
  logic [CW-1:0]      fifo_count;
  logic [31:0]        status;

  assign wr  = |memMappedAddr[MMIO_REGION_MSB:MMIO_REGION_LSB];
  assign dec = mmio_decode(wr, memMappedAddr);

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    logic          st, st_d;
    logic [DW-1:0] cnt, cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive samples
    // disagree with the current one; any agreeing sample restarts the count.
    always_comb begin
      st_d  = st;
      cnt_d = '0;
      if (sync2[g] != st) begin
        if (cnt == DW'(DEBOUNCE_CYCLES - 1)) st_d = sync2[g];
        else                                 cnt_d = cnt + DW'(1);
      end
    end

    // Per-button debounce state.
    always_ff @(posedge clk) begin
      if (rst) begin
        st  <= 1'b0;
        cnt <= '0;
      end else begin
        st  <= st_d;
        cnt <= cnt_d;
      end
    end

    assign stable[g]     = st;
    assign stable_nxt[g] = st_d;
  end

  // Rising edges are caught as stable changes, so the edge bit sets on the
  // same clock as the stable bit and wins over a coincident clear.
  assign rise     = stable_nxt & ~stable;
  assign clr_mask = dec.edge_clr ? memMappedDataOut[NUM_BTN-1:0] : '0;

  assign pop     = cmd_valid & cmd_ready;
  assign ovf_set = dec.push & full & ~pop;
  assign ovf_clr = dec.edge_clr & memMappedDataOut[8];

  // Sticky edge/overflow bits and the LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_bits <= '0;
      ovf       <= 1'b0;
      led       <= '0;
    end else begin
      edge_bits <= (edge_bits & ~clr_mask) | rise;
      ovf       <= ovf_set | (ovf & ~ovf_clr);
      if (dec.led) led <= memMappedDataOut[7:0];
    end
  end

  mmio_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dec.push),
    .pop   (pop),
    .wdata (memMappedDataOut),
    .head  (cmd_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign cmd_valid = ~empty;

  // Assemble the status word; unused button bits and the top bits read 0.
  always_comb begin
    status                   = '0;
    status[ST_BTN_LSB +: 8]  = 8'(stable);
    status[ST_EDGE_LSB +: 8] = 8'(edge_bits);
    status[ST_CNT_LSB +: 4]  = 4'(fifo_count);
    status[ST_FULL_BIT]      = full;
    status[ST_OVF_BIT]       = ovf;
  end

  // Status is registered, so the CPU always sees state one cycle old.
  always_ff @(posedge clk) begin
    if (rst) joystick_data <= '0;
    else     joystick_data <= status;
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder. A small model of the command FIFO pushes
// expected words into a queue as stores are driven; a monitor pops and
// compares on every handshake. Inputs change #1 after posedge.
module tb_mmio_responder;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memMappedAddr, memMappedDataOut;
  logic [31:0] joystick_data;
  logic [7:0]  btn_raw, led;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  int          mcnt;

  mmio_responder #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (8),
    .NUM_BTN         (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .memMappedAddr    (memMappedAddr),
    .memMappedDataOut (memMappedDataOut),
    .joystick_data    (joystick_data),
    .btn_raw          (btn_raw),
    .led              (led),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, updating the FIFO model with the inputs of each cycle.
  task automatic tick(input int n = 1);
    bit pop, acc;
    for (int i = 0; i < n; i++) begin
      if (rst) begin
        sb.delete();
        mcnt = 0;
      end else begin
        pop = (mcnt > 0) && cmd_ready;
        if (memMappedAddr == MMIO_CMD_PUSH) begin
          acc = (mcnt < 8) || pop;
          if (acc) begin
            sb.push_back(memMappedDataOut);
            mcnt++;
          end
        end
        if (pop) mcnt--;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memMappedAddr    = a;
    memMappedDataOut = d;
    tick(1);
    memMappedAddr    = '0;
    memMappedDataOut = '0;
  endtask

  // Handshake monitor: inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: observed=0x%08h expected=no output", cmd_data);
      end
      if (sb.size() != 0) chk("fifo_out", cmd_data, sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; memMappedAddr = '0; memMappedDataOut = '0;
    btn_raw = '0; cmd_ready = 1'b0; mcnt = 0;
    tick(2);
    rst = 1'b0;
    chk("rst_led",   32'(led), 32'h0);
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    chk("rst_data",  cmd_data, 32'h0);
    chk("rst_jd",    joystick_data, 32'h0);

    // LED register; non-decoded addresses leave it alone
    store(MMIO_LED, 32'hFFFF_FFA5);
    chk("led_wr", 32'(led), 32'hA5);
    store(32'h0, 32'h11);
    store(32'h0000_8010, 32'h11);
    chk("led_hold", 32'(led), 32'hA5);

    // 3-cycle glitch is shorter than the 4-sample debounce
    btn_raw = 8'h04; tick(3); btn_raw = 8'h00; tick(10);
    chk("glitch_btn",  32'(joystick_data[7:0]), 32'h0);
    chk("glitch_edge", 32'(joystick_data[15:8]), 32'h0);

    // stable changes 2+4=6 edges after the pin; status shows it one edge later
    btn_raw = 8'h04; tick(6);
    chk("btn_lat6", 32'(joystick_data[2]), 32'h0);
    tick(1);
    chk("btn_lat7", 32'(joystick_data[2]), 32'h1);
    chk("edge_set", 32'(joystick_data[10]), 32'h1);
    tick(3);
    store(MMIO_EDGE_CLR, 32'h4); tick(1);
    chk("edge_clr",  32'(joystick_data[10]), 32'h0);
    chk("btn_after", 32'(joystick_data[2]), 32'h1);
    btn_raw = 8'h00; tick(8);
    chk("btn_fall",  32'(joystick_data[2]), 32'h0);
    chk("fall_noedge", 32'(joystick_data[10]), 32'h0);

    // clear presented in the very cycle the edge sets: set wins
    btn_raw = 8'h04; tick(5);
    store(MMIO_EDGE_CLR, 32'h4); tick(1);
    chk("edge_win", 32'(joystick_data[10]), 32'h1);
    chk("btn_win",  32'(joystick_data[2]), 32'h1);
    store(MMIO_EDGE_CLR, 32'h4); tick(1);
    chk("edge_clr2", 32'(joystick_data[10]), 32'h0);
    btn_raw = 8'h00; tick(8);

    // fill with no consumer, overflow on the ninth push, then drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(MMIO_CMD_PUSH, 32'h100 + 32'(i));
    tick(1);
    chk("fill_cnt",  32'(joystick_data[19:16]), 32'h8);
    chk("fill_full", 32'(joystick_data[20]), 32'h1);
    chk("fill_ovf",  32'(joystick_data[21]), 32'h0);
    chk("fill_head", cmd_data, 32'h100);
    store(MMIO_CMD_PUSH, 32'h108); tick(1);
    chk("ovf_set", 32'(joystick_data[21]), 32'h1);
    chk("ovf_cnt", 32'(joystick_data[19:16]), 32'h8);
    cmd_ready = 1'b1; tick(9); cmd_ready = 1'b0;
    chk("drain_sb",    32'(sb.size()), 32'h0);
    chk("drain_valid", 32'(cmd_valid), 32'h0);
    tick(1);
    chk("drain_cnt",  32'(joystick_data[19:16]), 32'h0);
    chk("ovf_sticky", 32'(joystick_data[21]), 32'h1);
    store(MMIO_EDGE_CLR, 32'h100); tick(1);
    chk("ovf_clr", 32'(joystick_data[21]), 32'h0);

    // full FIFO with push and pop together: no drop, new word goes last
    for (int i = 0; i < 8; i++) store(MMIO_CMD_PUSH, 32'h200 + 32'(i));
    cmd_ready = 1'b1;
    store(MMIO_CMD_PUSH, 32'h208);
    cmd_ready = 1'b0;
    tick(1);
    chk("pp_cnt",  32'(joystick_data[19:16]), 32'h8);
    chk("pp_full", 32'(joystick_data[20]), 32'h1);
    chk("pp_ovf",  32'(joystick_data[21]), 32'h0);
    chk("pp_head", cmd_data, 32'h201);
    cmd_ready = 1'b1; tick(10); cmd_ready = 1'b0;
    chk("pp_sb", 32'(sb.size()), 32'h0);

    // push into empty with consumer ready: valid next cycle, then taken
    cmd_ready = 1'b1;
    chk("emp_valid0", 32'(cmd_valid), 32'h0);
    store(MMIO_CMD_PUSH, 32'h300);
    chk("emp_valid1", 32'(cmd_valid), 32'h1);
    chk("emp_data",   cmd_data, 32'h300);
    tick(1);
    chk("emp_valid2", 32'(cmd_valid), 32'h0);
    tick(1);
    chk("emp_cnt", 32'(joystick_data[19:16]), 32'h0);

    // head must hold under backpressure
    cmd_ready = 1'b0;
    store(MMIO_CMD_PUSH, 32'h400);
    store(MMIO_CMD_PUSH, 32'h401);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data",  cmd_data, 32'h400);
      chk("bp_valid", 32'(cmd_valid), 32'h1);
      tick(1);
    end
    cmd_ready = 1'b1; tick(3); cmd_ready = 1'b0;
    chk("bp_sb", 32'(sb.size()), 32'h0);

    // reset mid-operation with three commands queued
    for (int i = 0; i < 3; i++) store(MMIO_CMD_PUSH, 32'h500 + 32'(i));
    store(MMIO_LED, 32'h3C);
    tick(1);
    chk("pre_cnt", 32'(joystick_data[19:16]), 32'h3);
    rst = 1'b1; tick(2); rst = 1'b0;
    chk("mrst_valid", 32'(cmd_valid), 32'h0);
    chk("mrst_led",   32'(led), 32'h0);
    chk("mrst_jd",    joystick_data, 32'h0);
    chk("mrst_data",  cmd_data, 32'h0);
    tick(1);
    chk("post_jd",    joystick_data, 32'h0);
    chk("post_valid", 32'(cmd_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
